// File: rtl/y86_alu_pkg.sv
// Shared definitions for the Y86 ALU datapath.
// Contents: operand width W, op encodings (OP_ADD/OP_SUB), and the state
// encodings for the add_arbiter sequencer.
package y86_alu_pkg;

  // Fixed by the shared ripple adder; do not override.
  localparam int unsigned W = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StNeg  = 2'd1;
  localparam logic [1:0] StSum  = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

endpackage

// File: rtl/add_arbiter_add.sv
// Add: W-bit ripple-carry adder with no carry-in.
// Ports:
//   A, B           - operands
//   SUM            - A + B mod 2^W
//   CARRY_OVERFLOW - signed (two's complement) overflow of the addition
module Add
  import y86_alu_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] SUM,
  output logic         CARRY_OVERFLOW
);

  logic [W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign SUM[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign CARRY_OVERFLOW = carry[W] ^ carry[W-1];

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: shares one Add instance between two requesters (0 = execute,
// 1 = PC/address path) with round-robin arbitration and valid/ready handshakes.
// ADD takes one adder pass; SUB takes two (negate b, then a + neg_b) because
// the adder has no carry-in. Results come back as a one-cycle pulse with
// Y86 condition codes.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   req_valid/req_ready    - per-requester handshake (ready only in IDLE)
//   req_op, req_a, req_b   - per-requester op (0 ADD, 1 SUB) and operands
//   resp_valid             - one-cycle result pulse, no backpressure
//   resp_id                - requester the result belongs to
//   resp_result            - a+b or a-b mod 2^W
//   resp_zf/sf/of          - zero, sign, signed overflow
//   busy                   - sequencer not in IDLE
module add_arbiter
  import y86_alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_op,
  input  logic [1:0][W-1:0]   req_a,
  input  logic [1:0][W-1:0]   req_b,
  output logic                resp_valid,
  output logic                resp_id,
  output logic [W-1:0]        resp_result,
  output logic                resp_zf,
  output logic                resp_sf,
  output logic                resp_of,
  output logic                busy
);

  logic [1:0]   state_q, state_d;
  logic         last_id_q, last_id_d;
  logic         op_q, op_d;
  logic         id_q, id_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         ovf1_q, ovf1_d;
  logic         rid_q, rid_d;
  logic [W-1:0] res_q, res_d;
  logic         zf_q, zf_d;
  logic         sf_q, sf_d;
  logic         of_q, of_d;

  logic         gnt_id;
  logic         accept;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_ovf;

  Add u_add (
    .A              (add_a),
    .B              (add_b),
    .SUM            (add_sum),
    .CARRY_OVERFLOW (add_ovf)
  );

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    gnt_id    = (&req_valid) ? ~last_id_q : req_valid[1];
    accept    = (state_q == StIdle) && (|req_valid) && !rst;
    req_ready = 2'b00;
    if (accept) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  // Adder operands depend on state only.
  always_comb begin
    add_a = '0;
    add_b = '0;
    unique case (state_q)
      StNeg: begin
        add_a = ~b_q;
        add_b = {{(W-1){1'b0}}, 1'b1};
      end
      StSum: begin
        add_a = a_q;
        add_b = b_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    op_d      = op_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    ovf1_d    = ovf1_q;
    rid_d     = rid_q;
    res_d     = res_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d      = req_op[gnt_id];
          a_d       = req_a[gnt_id];
          b_d       = req_b[gnt_id];
          id_d      = gnt_id;
          last_id_d = gnt_id;
          state_d   = (req_op[gnt_id] == OP_SUB) ? StNeg : StSum;
        end
      end
      StNeg: begin
        b_d     = add_sum;
        ovf1_d  = add_ovf;
        state_d = StSum;
      end
      StSum: begin
        res_d   = add_sum;
        zf_d    = (add_sum == '0);
        sf_d    = add_sum[W-1];
        // Negating the most negative b overflows; xor-ing both passes
        // recovers the true overflow of a - b in that case.
        of_d    = (op_q == OP_SUB) ? (ovf1_q ^ add_ovf) : add_ovf;
        rid_d   = id_q;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_id_q <= 1'b1;
      op_q      <= OP_ADD;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      ovf1_q    <= 1'b0;
      rid_q     <= 1'b0;
      res_q     <= '0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      op_q      <= op_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ovf1_q    <= ovf1_d;
      rid_q     <= rid_d;
      res_q     <= res_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
    end
  end

  assign resp_valid  = (state_q == StResp);
  assign resp_id     = rid_q;
  assign resp_result = res_q;
  assign resp_zf     = zf_q;
  assign resp_sf     = sf_q;
  assign resp_of     = of_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op;
  logic [1:0][63:0] req_a;
  logic [1:0][63:0] req_b;
  logic             resp_valid;
  logic             resp_id;
  logic [63:0]      resp_result;
  logic             resp_zf, resp_sf, resp_of;
  logic             busy;

  add_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zf     (resp_zf),
    .resp_sf     (resp_sf),
    .resp_of     (resp_of),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] res;
    logic        zf;
    logic        sf;
    logic        of;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [63:0] MaxPos = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;
  localparam logic [63:0] AllOne = 64'hFFFF_FFFF_FFFF_FFFF;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain arithmetic plus sign-rule overflow.
  function automatic exp_t model(input int p, input logic op, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t e;
    e.id  = p;
    e.res = op ? (a - b) : (a + b);
    e.zf  = (e.res == 64'd0);
    e.sf  = e.res[63];
    e.of  = op ? ((a[63] != b[63]) && (e.res[63] != a[63]))
               : ((a[63] == b[63]) && (e.res[63] != a[63]));
    e.acc_cyc = 0;
    e.lat = op ? 3 : 2;
    return e;
  endfunction

  // Scoreboard side: pop and compare on every response pulse.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      n_total++;
      if (req_ready !== 2'b00)
        $display("FAIL ready_outside_idle: req_ready=%b required 00", req_ready);
      else n_pass++;
    end
    if (resp_valid === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_resp: id=%0d result=%h, none expected", resp_id, resp_result);
      end else begin
        mon_e = sb.pop_front();
        if ({resp_id, resp_result, resp_zf, resp_sf, resp_of} !==
            {mon_e.id[0], mon_e.res, mon_e.zf, mon_e.sf, mon_e.of})
          $display("FAIL resp_data: got id=%0d res=%h zf=%b sf=%b of=%b, required id=%0d res=%h zf=%b sf=%b of=%b",
                   resp_id, resp_result, resp_zf, resp_sf, resp_of,
                   mon_e.id, mon_e.res, mon_e.zf, mon_e.sf, mon_e.of);
        else n_pass++;
        n_total++;
        if ((cyc - mon_e.acc_cyc) != mon_e.lat)
          $display("FAIL resp_latency: got T+%0d required T+%0d", cyc - mon_e.acc_cyc, mon_e.lat);
        else n_pass++;
      end
    end
  end

  // Called at a negedge; returns at a negedge after the accept edge.
  task automatic issue(input int p, input logic op, input logic [63:0] a,
                       input logic [63:0] b, output int acc);
    exp_t e;
    bit   ok;
    e = model(p, op, a, b);
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_a[p]     = a;
    req_b[p]     = b;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_ready[p] === 1'b1) begin
        e.acc_cyc = cyc;
        acc = cyc;
        sb.push_back(e);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: port %0d never ready, required ready within 20 cycles", p);
    end else begin
      @(posedge clk);
      #1;
    end
    req_valid[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (sb.size() == 0 && busy === 1'b0) done = 1'b1;
      @(negedge clk);
    end
    if (!done) begin
      n_total++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b required 00", req_ready);
    else n_pass++;
    n_total++;
    if ({resp_valid, busy} !== 2'b00)
      $display("FAIL reset_valid_busy: got %b required 00", {resp_valid, busy});
    else n_pass++;
    n_total++;
    if ({resp_id, resp_zf, resp_sf, resp_of, resp_result} !== 68'd0)
      $display("FAIL reset_resp: got id=%b zf=%b sf=%b of=%b res=%h required all 0",
               resp_id, resp_zf, resp_sf, resp_of, resp_result);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL first_tie: req_ready=%b required 01", req_ready);
    else n_pass++;
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_add();
    int acc;
    issue(0, 1'b0, 64'd5, 64'd7, acc);
    wait_drain();
  endtask

  task automatic test_sub();
    int acc;
    issue(1, 1'b1, 64'd3, 64'd3, acc);
    wait_drain();
  endtask

  task automatic test_overflow();
    int acc;
    issue(0, 1'b0, MaxPos, 64'd1, acc);
    wait_drain();
    issue(1, 1'b1, 64'd0, MinNeg, acc);
    wait_drain();
    issue(0, 1'b1, AllOne, MinNeg, acc);
    wait_drain();
    issue(1, 1'b1, MinNeg, 64'd1, acc);
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      issue(i % 2, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, acc);
      wait_drain();
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3, a4;
    issue(1, 1'b0, 64'd100, 64'd23, a1);
    issue(1, 1'b0, 64'd9, AllOne, a2);
    issue(1, 1'b1, 64'd50, 64'd80, a3);
    issue(1, 1'b1, 64'd1, 64'd2, a4);
    wait_drain();
    n_total++;
    if (a2 - a1 != 3) $display("FAIL b2b_add_gap: got %0d required 3", a2 - a1);
    else n_pass++;
    n_total++;
    if (a3 - a2 != 3) $display("FAIL b2b_add_sub_gap: got %0d required 3", a3 - a2);
    else n_pass++;
    n_total++;
    if (a4 - a3 != 4) $display("FAIL b2b_sub_gap: got %0d required 4", a4 - a3);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int acc;
    issue(1, 1'b0, MaxPos, 64'd1, acc);
    wait_drain();
    issue(0, 1'b1, 64'd10, 64'd3, acc);
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %b required 1", busy);
    else n_pass++;
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    sb.delete();
    n_total++;
    if ({resp_valid, busy, req_ready} !== 4'b0000)
      $display("FAIL mid_reset_ctrl: valid=%b busy=%b ready=%b required 0 0 00",
               resp_valid, busy, req_ready);
    else n_pass++;
    n_total++;
    if ({resp_id, resp_zf, resp_sf, resp_of, resp_result} !== 68'd0)
      $display("FAIL mid_reset_resp: got id=%b zf=%b sf=%b of=%b res=%h required all 0",
               resp_id, resp_zf, resp_sf, resp_of, resp_result);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    issue(0, 1'b1, 64'd10, 64'd3, acc);
    wait_drain();
  endtask

  task automatic test_alternate();
    int order[$];
    int got;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_op[p] = 1'($urandom_range(0, 1));
      req_a[p]  = {$urandom, $urandom};
      req_b[p]  = {$urandom, $urandom};
    end
    req_valid = 2'b11;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      #1;
      got = -1;
      for (int p = 0; p < 2; p++) begin
        if (req_ready[p] === 1'b1) begin
          exp_t e;
          e = model(p, req_op[p], req_a[p], req_b[p]);
          e.acc_cyc = cyc;
          sb.push_back(e);
          order.push_back(p);
          got = p;
        end
      end
      @(posedge clk);
      #1;
      if (got >= 0) begin
        req_op[got] = 1'($urandom_range(0, 1));
        req_a[got]  = {$urandom, $urandom};
        req_b[got]  = {$urandom, $urandom};
      end
      if (order.size() == 4) req_valid = 2'b00;
      @(negedge clk);
    end
    req_valid = 2'b00;
    n_total++;
    if (order.size() != 4) $display("FAIL alt_count: got %0d grants required 4", order.size());
    else n_pass++;
    for (int k = 0; k < order.size(); k++) begin
      n_total++;
      if (order[k] != k % 2) $display("FAIL alt_grant%0d: got %0d required %0d", k, order[k], k % 2);
      else n_pass++;
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    test_alternate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares one 64-bit ripple adder (`Add`) between two requesters: the execute stage (port 0) and the PC/address path (port 1). Round-robin arbitration with valid/ready handshakes. Sequences ADD as one adder pass. Sequences SUB as two passes, `~b + 1` then `a + neg_b`, because the adder has no carry-in. Each result is returned with Y86 condition codes (ZF/SF/OF) as a one-cycle response pulse.

## Interface
- `W`, 64: operand width; fixed by the adder and not to be overridden.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 2: bit i = requester i has an operation.
- `req_ready` out 2: bit i = requester i accepted this cycle (`req_valid[i] && req_ready[i]`).
- `req_op` in 2x1 (`req_op[i]`): 0 = ADD, 1 = SUB.
- `req_a` in 2x64: operand a per requester.
- `req_b` in 2x64: operand b per requester.
- `resp_valid` out 1: result pulse, one cycle, no backpressure.
- `resp_id` out 1: requester the result belongs to.
- `resp_result` out 64: a+b or a−b (two's complement, mod 2^64).
- `resp_zf`, `resp_sf`, `resp_of` out 1 each: result==0, result[63], signed overflow.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, NEG, SUM, RESP.
- IDLE: compute grant. If only one `req_valid` is set, that requester wins. If both are set, the requester not served last wins (`last_id` register).
  - `req_ready[grant]` = 1 only in IDLE, combinationally.
  - On acceptance, latch `op`, `a`, `b`, `id`; set `last_id` = id.
  - Next state: NEG if SUB, SUM if ADD.
- NEG: adder inputs = (`~b`, 64'd1). Store the sum into the b register and its overflow into `ovf1`. Next state SUM.
- SUM: adder inputs = (`a`, `b`). Register result and overflow `ovf2`.
  - OF = `ovf2` for ADD; OF = `ovf1 ^ ovf2` for SUB. This covers b = 0x8000…0: `ovf1`=1 and the final OF equals (a ≥ 0).
  - ZF = (result == 0); SF = result[63].
  - Next state RESP.
- RESP: `resp_valid` = 1 for exactly this cycle; `resp_*` hold the registered values. Next state IDLE.
- Adder input mux is driven only by state; adder inputs in IDLE/RESP are don't-care (drive 0).
- `req_*` inputs are ignored outside IDLE; requesters hold `valid`/data until ready.

## Timing
- Reset (async assert, sync deassert at clk):
  - state = IDLE, `last_id` = 1, so port 0 wins the first tie.
  - `resp_valid` = 0, `resp_id` = 0, `resp_result` = 0, `resp_zf`/`resp_sf`/`resp_of` = 0, `busy` = 0.
  - `req_ready` is combinational and is 0 while `rst` is high.
- Latency from the acceptance edge T: ADD `resp_valid` in cycle T+2; SUB in T+3.
- Throughput: one accept per 3 cycles (ADD) or 4 cycles (SUB). The next accept can occur the cycle after RESP.
- `resp_*` registers keep their last values after the pulse, until the next SUM.
- Reset mid-operation (NEG/SUM/RESP): the operation is dropped, no `resp_valid` is produced, the FSM returns to IDLE. Requesters re-issue.
- Both valid every cycle: grants alternate 0,1,0,1….
- A single requester that is always valid is granted back-to-back with no idle fairness gap.

## Structure
- Shared package/header `y86_alu_pkg`: op encodings (`OP_ADD`, `OP_SUB`), FSM state encodings, `W`.
- One sub-module: existing `Add` (A, B, SUM, CARRY_OVERFLOW), instantiated exactly once. No second adder and no behavioural `+`/`-` in this block.
- Remainder is in this block: arbiter, FSM, operand/result registers, CC logic.

## Test plan
- ADD port 0, a=5, b=7 → `resp_valid` at T+2, id=0, result=12, ZF=0, SF=0, OF=0.
- SUB port 1, a=3, b=3 → `resp_valid` at T+3, result=0, ZF=1, SF=0, OF=0.
- ADD a=0x7FFF…FFFF, b=1 → result 0x8000…0000, SF=1, OF=1.
- SUB a=0, b=0x8000…0000 → result 0x8000…0000, OF=1. SUB a=−1, b=0x8000…0000 → result 0x7FFF…FFFF, OF=0.
- Both ports valid continuously → first grant port 0, then strictly alternating; `resp_id` sequence 0,1,0,1; `req_ready` never high outside IDLE.
- Assert `rst` in NEG of a SUB → outputs at reset values immediately, no `resp_valid`; after release, the re-issued request completes normally.
